half_sub: RTL and testbench

- Registered, width-parameterised half subtractor: computes per-bit difference D = A − B (no borrow-in) and per-bit borrow-out B_0.
- Primitive building block for the FullAddSub datapath; full subtractors chain two of these plus an OR.
- Default WIDTH=1 reproduces the classic single-bit half subtractor, with outputs registered on CLK.

---
 rtl/half_sub.sv | 42 ++++
 tb/tb_half_sub.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/half_sub.sv
// Registered, width-parameterised half subtractor: each lane computes A-B with
// no borrow-in; difference, borrow and an any-borrow flag update on CLK when EN is high.
module half_sub #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] B_0,
  output logic             VALID,
  output logic             BORROW_ANY
);

  logic [WIDTH-1:0] diff_next;
  logic [WIDTH-1:0] borrow_next;

  always_comb begin
    diff_next   = A ^ B;
    borrow_next = ~A & B;
  end

  // BORROW_ANY reduces the value being loaded, so it always agrees with B_0.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      D          <= '0;
      B_0        <= '0;
      VALID      <= 1'b0;
      BORROW_ANY <= 1'b0;
    end else begin
      VALID <= EN;
      if (EN) begin
        D          <= diff_next;
        B_0        <= borrow_next;
        BORROW_ANY <= |borrow_next;
      end
    end
  end

endmodule

// File: tb/tb_half_sub.sv
// Scoreboard bench for half_sub: WIDTH 1, 4 and 8 instances share one stimulus
// stream; expected values come from a behavioural reference model.
module tb_half_sub;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
  } stim_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic [7:0] b;

  logic [0:0] d1, b01;
  logic [3:0] d4, b04;
  logic [7:0] d8, b08;
  logic       v1, v4, v8;
  logic       any1, any4, any8;

  stim_t sb_q[$];
  int unsigned n_tests;
  int unsigned n_fail;

  // Reference model state (8 lanes; narrower instances see the low lanes).
  logic [7:0] m_d;
  logic [7:0] m_b0;
  logic       m_v;

  half_sub #(.WIDTH(1)) u_w1 (
    .CLK(clk), .RST(rst), .EN(en), .A(a[0:0]), .B(b[0:0]),
    .D(d1), .B_0(b01), .VALID(v1), .BORROW_ANY(any1)
  );

  half_sub #(.WIDTH(4)) u_w4 (
    .CLK(clk), .RST(rst), .EN(en), .A(a[3:0]), .B(b[3:0]),
    .D(d4), .B_0(b04), .VALID(v4), .BORROW_ANY(any4)
  );

  half_sub #(.WIDTH(8)) u_w8 (
    .CLK(clk), .RST(rst), .EN(en), .A(a), .B(b),
    .D(d8), .B_0(b08), .VALID(v8), .BORROW_ANY(any8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push it, then pop and compare after the edge.
  task automatic drive(input logic r, input logic e, input logic [7:0] av, input logic [7:0] bv);
    stim_t s;
    rst = r;
    en  = e;
    a   = av;
    b   = bv;
    s.rst = r; s.en = e; s.a = av; s.b = bv;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      s = sb_q.pop_front();
      if (!s.rst) begin
        m_d = '0; m_b0 = '0; m_v = 1'b0;
      end else begin
        m_v = s.en;
        if (s.en) begin
          for (int unsigned i = 0; i < 8; i++) begin
            // Two's-complement A-B per lane: {borrow, diff}
            logic [1:0] r2;
            r2 = {1'b0, s.a[i]} - {1'b0, s.b[i]};
            m_d[i]  = r2[0];
            m_b0[i] = r2[1];
          end
        end
      end
      check_val("w1_d",     {31'd0, d1},   {31'd0, m_d[0]});
      check_val("w1_b0",    {31'd0, b01},  {31'd0, m_b0[0]});
      check_val("w1_valid", {31'd0, v1},   {31'd0, m_v});
      check_val("w1_any",   {31'd0, any1}, {31'd0, m_b0[0]});
      check_val("w4_d",     {28'd0, d4},   {28'd0, m_d[3:0]});
      check_val("w4_b0",    {28'd0, b04},  {28'd0, m_b0[3:0]});
      check_val("w4_valid", {31'd0, v4},   {31'd0, m_v});
      check_val("w4_any",   {31'd0, any4}, {31'd0, |m_b0[3:0]});
      check_val("w8_d",     {24'd0, d8},   {24'd0, m_d});
      check_val("w8_b0",    {24'd0, b08},  {24'd0, m_b0});
      check_val("w8_valid", {31'd0, v8},   {31'd0, m_v});
      check_val("w8_any",   {31'd0, any8}, {31'd0, |m_b0});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_d = '0; m_b0 = '0; m_v = 1'b0;

    // Reset with active inputs must still clear everything.
    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    check_val("reset_d_const", {24'd0, d8}, 32'd0);
    check_val("reset_valid_const", {31'd0, v8}, 32'd0);

    // Truth table on every lane, back-to-back.
    drive(1'b1, 1'b1, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 8'h00, 8'hFF);
    check_val("tt01_d_const", {24'd0, d8}, 32'hFF);
    check_val("tt01_any_const", {31'd0, any1}, 32'd1);
    drive(1'b1, 1'b1, 8'hFF, 8'h00);
    check_val("tt10_b0_const", {24'd0, b08}, 32'h00);
    drive(1'b1, 1'b1, 8'hFF, 8'hFF);
    check_val("tt11_d_const", {24'd0, d8}, 32'h00);

    // Hold: load a borrow, then EN=0 with changed inputs for 3 edges.
    drive(1'b1, 1'b1, 8'h00, 8'hFF);
    for (int unsigned i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'hFF, 8'hFF);
    check_val("hold_b0_const", {28'd0, b04}, 32'hF);
    check_val("hold_valid_const", {31'd0, v4}, 32'd0);

    // Multi-lane patterns.
    drive(1'b1, 1'b1, 8'h35, 8'hC3);
    check_val("ml_d4_const", {28'd0, d4}, 32'h6);
    check_val("ml_b04_const", {28'd0, b04}, 32'h2);
    drive(1'b1, 1'b1, 8'hFF, 8'h00);
    check_val("ml_any4_const", {31'd0, any4}, 32'd0);

    // Reset mid-stream, then resume.
    drive(1'b1, 1'b1, 8'h0F, 8'hF0);
    drive(1'b0, 1'b1, 8'h0F, 8'hF0);
    drive(1'b1, 1'b1, 8'h0F, 8'hF0);
    check_val("resume_b08_const", {24'd0, b08}, 32'hF0);

    // Randomised traffic with occasional resets.
    for (int unsigned i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) != 0),
            8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
